// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher engine beside data_mem: encrypts a padded frame or recovers seed/taps and decrypts it.
// <=2 cycles per byte, no backpressure. Define LFSR_CRYPT_STATUS_EN for tap_idx/err outputs and abort-on-miss.
module lfsr_crypt_engine #(
   parameter int W         = 8,
   parameter int ADDR_W    = 8,
   parameter int FRAME_LEN = 64,
   parameter int MSG_LEN   = 41,
   parameter int SRC_BASE  = 0,
   parameter int DST_BASE  = 64,
   parameter int NUM_CAND  = 8,
   parameter int PRE_MIN   = 8,
   parameter logic [W-1:0] PAD = W'(32'h20)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic [W-1:0]            taps_i,
   input  logic [W-1:0]            seed_i,
   input  logic [ADDR_W-1:0]       pre_len_i,
   input  logic [NUM_CAND*W-1:0]   cand_taps_i,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    mem_rd_o,
   input  logic [W-1:0]            mem_rdata_i,
   output logic                    mem_we_o,
   output logic [W-1:0]            mem_wdata_o,
   output logic                    busy_o,
   output logic                    done_o
`ifdef LFSR_CRYPT_STATUS_EN
   ,
   output logic [$clog2(NUM_CAND)-1:0] tap_idx_o,
   output logic                    err_o
`endif
);

   localparam int CW    = $clog2(NUM_CAND);
   localparam int CNT_W = ADDR_W + 1;

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam cnt_t           ONE        = cnt_t'(1);
   localparam cnt_t           FRAME_LAST = cnt_t'(FRAME_LEN - 1);
   localparam cnt_t           MSG_LAST   = cnt_t'(MSG_LEN - 1);
   localparam cnt_t           MSG_END    = cnt_t'(MSG_LEN);
   localparam cnt_t           PRE_LAST   = cnt_t'(PRE_MIN - 1);
   localparam addr_t          SRC_A      = addr_t'(SRC_BASE);
   localparam addr_t          DST_A      = addr_t'(DST_BASE);
   localparam logic [CW-1:0]  LAST_CAND  = CW'(NUM_CAND - 1);

   typedef enum logic [3:0] {
      IDLE, E_RD, E_WR, D_SEED_RD, D_SEED_CK, D_SRCH_RD, D_SRCH_CK,
      D_RUN_RD, D_RUN_CK, D_FILL, DONE
   } state_t;

   state_t                state_q, state_d;
   cnt_t                  idx_q, idx_d;
   cnt_t                  n_q, n_d;
   logic [W-1:0]          lfsr_q, lfsr_d;
   logic [W-1:0]          seed_q, seed_d;
   logic [W-1:0]          taps_q, taps_d;
   addr_t                 pre_q, pre_d;
   logic [NUM_CAND*W-1:0] cands_q, cands_d;
   logic [CW-1:0]         cand_q, cand_d;
   logic                  started_q, started_d;
`ifdef LFSR_CRYPT_STATUS_EN
   logic                  err_q, err_d;
`endif

   logic                  rd_c, we_c, wr_msg;
   addr_t                 addr_c;
   logic [W-1:0]          wdata_c, cur_taps, plain;

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic [W-1:0] t);
      return {s[W-2:0], ^(s & t)};
   endfunction

   function automatic logic in_msg(input cnt_t i, input addr_t pre);
      cnt_t lo;
      lo = {1'b0, pre};
      return (i >= lo) && (i < lo + MSG_END);
   endfunction

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      lfsr_d    = lfsr_q;
      seed_d    = seed_q;
      taps_d    = taps_q;
      pre_d     = pre_q;
      cands_d   = cands_q;
      cand_d    = cand_q;
      started_d = started_q;
`ifdef LFSR_CRYPT_STATUS_EN
      err_d     = err_q;
`endif
      rd_c      = 1'b0;
      we_c      = 1'b0;
      addr_c    = '0;
      wdata_c   = '0;
      wr_msg    = 1'b0;
      cur_taps  = cands_q[cand_q*W +: W];
      plain     = mem_rdata_i ^ lfsr_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               idx_d     = '0;
               n_d       = '0;
               started_d = 1'b0;
               cand_d    = '0;
               cands_d   = cand_taps_i;
`ifdef LFSR_CRYPT_STATUS_EN
               err_d     = 1'b0;
`endif
               if (mode_i) begin
                  state_d = D_SEED_RD;
               end else begin
                  lfsr_d  = seed_i;
                  taps_d  = taps_i;
                  pre_d   = pre_len_i;
                  state_d = in_msg('0, pre_len_i) ? E_RD : E_WR;
               end
            end
         end
         E_RD: begin
            rd_c    = 1'b1;
            addr_c  = SRC_A + addr_t'(idx_q - {1'b0, pre_q});
            state_d = E_WR;
         end
         E_WR: begin
            we_c    = 1'b1;
            addr_c  = DST_A + addr_t'(idx_q);
            wdata_c = (in_msg(idx_q, pre_q) ? mem_rdata_i : PAD) ^ lfsr_q;
            lfsr_d  = lfsr_step(lfsr_q, taps_q);
            idx_d   = idx_q + ONE;
            if (idx_q == FRAME_LAST) state_d = DONE;
            else                     state_d = in_msg(idx_q + ONE, pre_q) ? E_RD : E_WR;
         end
         D_SEED_RD: begin
            rd_c    = 1'b1;
            addr_c  = DST_A;
            state_d = D_SEED_CK;
         end
         D_SEED_CK: begin
            seed_d  = mem_rdata_i ^ PAD;
            lfsr_d  = mem_rdata_i ^ PAD;
            idx_d   = '0;
            state_d = D_SRCH_RD;
         end
         D_SRCH_RD: begin
            rd_c    = 1'b1;
            addr_c  = DST_A + addr_t'(idx_q);
            state_d = D_SRCH_CK;
         end
         D_SRCH_CK: begin
            // Every candidate restarts from the recovered seed; lowest passing index wins.
            if (plain != PAD) begin
               lfsr_d = seed_q;
               idx_d  = '0;
               if (cand_q == LAST_CAND) begin
`ifdef LFSR_CRYPT_STATUS_EN
                  err_d   = 1'b1;
                  state_d = DONE;
`else
                  cand_d  = '0;
                  taps_d  = cands_q[W-1:0];
                  state_d = D_RUN_RD;
`endif
               end else begin
                  cand_d  = cand_q + 1'b1;
                  state_d = D_SRCH_RD;
               end
            end else if (idx_q == PRE_LAST) begin
               taps_d  = cur_taps;
               lfsr_d  = seed_q;
               idx_d   = '0;
               state_d = D_RUN_RD;
            end else begin
               lfsr_d  = lfsr_step(lfsr_q, cur_taps);
               idx_d   = idx_q + ONE;
               state_d = D_SRCH_RD;
            end
         end
         D_RUN_RD: begin
            rd_c    = 1'b1;
            addr_c  = DST_A + addr_t'(idx_q);
            state_d = D_RUN_CK;
         end
         D_RUN_CK: begin
            lfsr_d = lfsr_step(lfsr_q, taps_q);
            idx_d  = idx_q + ONE;
            wr_msg = started_q || (plain != PAD);
            if (wr_msg) begin
               we_c      = 1'b1;
               addr_c    = SRC_A + addr_t'(n_q);
               wdata_c   = plain;
               n_d       = n_q + ONE;
               started_d = 1'b1;
            end
            if (wr_msg && (n_q == MSG_LAST)) state_d = DONE;
            else if (idx_q == FRAME_LAST)    state_d = D_FILL;
            else                             state_d = D_RUN_RD;
         end
         D_FILL: begin
            we_c    = 1'b1;
            addr_c  = SRC_A + addr_t'(n_q);
            wdata_c = PAD;
            n_d     = n_q + ONE;
            if (n_q == MSG_LAST) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         n_q       <= '0;
         lfsr_q    <= '0;
         seed_q    <= '0;
         taps_q    <= '0;
         pre_q     <= '0;
         cands_q   <= '0;
         cand_q    <= '0;
         started_q <= 1'b0;
`ifdef LFSR_CRYPT_STATUS_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         n_q       <= n_d;
         lfsr_q    <= lfsr_d;
         seed_q    <= seed_d;
         taps_q    <= taps_d;
         pre_q     <= pre_d;
         cands_q   <= cands_d;
         cand_q    <= cand_d;
         started_q <= started_d;
`ifdef LFSR_CRYPT_STATUS_EN
         err_q     <= err_d;
`endif
      end
   end

   // Strobes are masked by reset so an abort never lands a write on the reset edge.
   assign mem_we_o    = we_c & ~reset_i;
   assign mem_rd_o    = rd_c & ~reset_i;
   assign mem_addr_o  = addr_c;
   assign mem_wdata_o = wdata_c;
   assign busy_o      = (state_q != IDLE) && (state_q != DONE);
   assign done_o      = (state_q == DONE);
`ifdef LFSR_CRYPT_STATUS_EN
   assign tap_idx_o   = cand_q;
   assign err_o       = err_q;
`endif

endmodule
